// File: rtl/accum_stage_pkg.sv
// Local definitions for the attention accumulator stage.
// Purpose : FSM state encoding, key counter width/limit, a debug view of
//           the FSM and a saturating key-counter increment helper.
// Ports   : none (package only).

package accum_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_FB_FULL  = 2'd1,
    ST_ROW_FULL = 2'd2
  } acc_state_t;

  localparam int KEY_CNT_W = 8;
  localparam logic [KEY_CNT_W-1:0] KEY_CNT_MAX = 8'hff;

  // Observable snapshot of the controller, handy for binding checkers.
  typedef struct packed {
    acc_state_t           state;
    logic [KEY_CNT_W-1:0] key_cnt;
  } acc_dbg_t;

  function automatic logic [KEY_CNT_W-1:0] key_cnt_inc(input logic [KEY_CNT_W-1:0] c);
    return (c == KEY_CNT_MAX) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/sys_defs.sv
// Shared system definitions.
// Purpose : value format of the scaled-V / accumulator lanes that flow
//           between the expmul stages, the accumulator and the normaliser,
//           together with the saturation limits of that format and the
//           embedding dimension used to size vector lanes.
// Ports   : none (package only).

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 4
`endif

package sys_defs;

  // Signed fixed-point lane produced by the expmul stages.
  typedef logic signed [15:0] EXPMUL_VSHIFT_QT;

  localparam EXPMUL_VSHIFT_QT EXPMUL_VSHIFT_QT_MAX = 16'sh7fff;
  localparam EXPMUL_VSHIFT_QT EXPMUL_VSHIFT_QT_MIN = 16'sh8000;

endpackage

// File: rtl/sat_add.sv
// Per-lane signed saturating adder.
// Purpose : sum = a + b clamped to the EXPMUL_VSHIFT_QT range (no wrap).
// Ports   : a, b (in)  signed lane operands
//           sum  (out) saturated signed sum

module sat_add
  import sys_defs::*;
(
  input  EXPMUL_VSHIFT_QT a,
  input  EXPMUL_VSHIFT_QT b,
  output EXPMUL_VSHIFT_QT sum
);

  localparam int W = $bits(EXPMUL_VSHIFT_QT);

  logic [W:0] wide;

  always_comb begin
    // One guard bit: overflow shows as the two top bits disagreeing,
    // and the guard bit gives the true sign of the result.
    wide = {a[W-1], a} + {b[W-1], b};
    if (wide[W] != wide[W-1]) begin
      sum = wide[W] ? EXPMUL_VSHIFT_QT_MIN : EXPMUL_VSHIFT_QT_MAX;
    end else begin
      sum = wide[W-1:0];
    end
  end

endmodule

// File: rtl/accum_stage.sv
// Online-softmax accumulator stage.
// Purpose : joins the scaled-V stream with the rescaled-accumulator stream,
//           adds them lane-wise with saturation and holds the result in a
//           single output slot. Mid-row results go back to the O-side expmul
//           stage as feedback; the last key of a row produces a finished row
//           (lane DIM-1 carries the softmax denominator).
// Ports   : clk, rst                      clock, synchronous active-high reset
//           v_vld_in/v_rdy_out/v_in       scaled-V input, v_first_in/v_last_in row markers
//           o_vld_in/o_rdy_out/o_in       rescaled accumulator input
//           fb_vld_out/fb_rdy_in/fb_out   partial accumulator feedback
//           row_vld_out/row_rdy_in/row_out finished row
//           key_cnt_out                   keys accumulated in the current row
//           err_out                       sticky protocol error
//
// Handshake: a transfer happens on a clock edge where valid and ready are both
// high. Producers hold valid and data until accepted. Input readys are a
// combinational function of the input valids and the slot state (a join),
// so they may drop while valid is low; output valids come from registers and
// the slot data stays stable while valid && !ready.

module accum_stage
  import sys_defs::*;
  import accum_stage_pkg::*;
#(
  parameter int DIM = `MAX_EMBEDDING_DIM + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          v_vld_in,
  output logic                          v_rdy_out,
  input  EXPMUL_VSHIFT_QT [DIM-1:0]     v_in,
  input  logic                          v_first_in,
  input  logic                          v_last_in,
  input  logic                          o_vld_in,
  output logic                          o_rdy_out,
  input  EXPMUL_VSHIFT_QT [DIM-1:0]     o_in,
  output logic                          fb_vld_out,
  input  logic                          fb_rdy_in,
  output EXPMUL_VSHIFT_QT [DIM-1:0]     fb_out,
  output logic                          row_vld_out,
  input  logic                          row_rdy_in,
  output EXPMUL_VSHIFT_QT [DIM-1:0]     row_out,
  output logic [KEY_CNT_W-1:0]          key_cnt_out,
  output logic                          err_out
);

  acc_state_t                 state_q;
  EXPMUL_VSHIFT_QT [DIM-1:0]  slot_q;
  EXPMUL_VSHIFT_QT [DIM-1:0]  o_eff;
  EXPMUL_VSHIFT_QT [DIM-1:0]  sum_d;
  logic [KEY_CNT_W-1:0]       key_cnt_q;
  logic                       row_closed_q;
  logic                       err_q;
  logic                       drain;
  logic                       slot_free;
  logic                       fire;
  acc_dbg_t                   dbg;

  always_comb begin
    drain     = ((state_q == ST_FB_FULL)  && fb_rdy_in) ||
                ((state_q == ST_ROW_FULL) && row_rdy_in);
    // A draining slot can be refilled on the same edge.
    slot_free = (state_q == ST_EMPTY) || drain;
    // The first key of a row has no accumulator to join with.
    fire      = !rst && v_vld_in && (v_first_in || o_vld_in) && slot_free;
  end

  assign v_rdy_out = fire;
  assign o_rdy_out = fire && !v_first_in;

  always_comb begin
    o_eff = v_first_in ? '0 : o_in;
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    sat_add u_sat_add (
      .a   (v_in[g]),
      .b   (o_eff[g]),
      .sum (sum_d[g])
    );
  end

  // row_closed_q marks the cycle after a last-key fire: the final count is
  // still shown, then cleared unless a new row starts on that very edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      slot_q       <= '0;
      key_cnt_q    <= '0;
      row_closed_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (fire) begin
        slot_q       <= sum_d;
        state_q      <= v_last_in ? ST_ROW_FULL : ST_FB_FULL;
        key_cnt_q    <= (v_first_in || row_closed_q) ? 8'd1 : key_cnt_inc(key_cnt_q);
        row_closed_q <= v_last_in;
      end else begin
        if (drain) begin
          state_q <= ST_EMPTY;
        end
        if (row_closed_q) begin
          key_cnt_q    <= '0;
          row_closed_q <= 1'b0;
        end
      end
      // A closed row's lingering count is not an open row, so a back-to-back
      // first key there is legal.
      if (fire && v_first_in && (key_cnt_q != '0) && !row_closed_q) begin
        err_q <= 1'b1;
      end
      if (o_vld_in && (key_cnt_q == '0) && (state_q == ST_EMPTY)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dbg = '{state: state_q, key_cnt: key_cnt_q};

  assign fb_vld_out  = (dbg.state == ST_FB_FULL);
  assign row_vld_out = (dbg.state == ST_ROW_FULL);
  assign fb_out      = slot_q;
  assign row_out     = slot_q;
  assign key_cnt_out = dbg.key_cnt;
  assign err_out     = err_q;

endmodule

// File: tb/tb_accum_stage.sv
module tb_accum_stage;

  localparam int DIM = 5;
  localparam int W   = 16;
  typedef logic [DIM-1:0][W-1:0] vec_t;

  typedef struct {
    logic [W-1:0] o;
    logic [W-1:0] v;
    logic [W-1:0] exp;
  } sat_vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       v_vld_in, v_rdy_out, v_first_in, v_last_in;
  logic       o_vld_in, o_rdy_out;
  vec_t       v_in, o_in, fb_out, row_out;
  logic       fb_vld_out, fb_rdy_in, row_vld_out, row_rdy_in;
  logic [7:0] key_cnt_out;
  logic       err_out;

  always #5 clk = ~clk;

  accum_stage #(.DIM(DIM)) dut (
    .clk         (clk),
    .rst         (rst),
    .v_vld_in    (v_vld_in),
    .v_rdy_out   (v_rdy_out),
    .v_in        (v_in),
    .v_first_in  (v_first_in),
    .v_last_in   (v_last_in),
    .o_vld_in    (o_vld_in),
    .o_rdy_out   (o_rdy_out),
    .o_in        (o_in),
    .fb_vld_out  (fb_vld_out),
    .fb_rdy_in   (fb_rdy_in),
    .fb_out      (fb_out),
    .row_vld_out (row_vld_out),
    .row_rdy_in  (row_rdy_in),
    .row_out     (row_out),
    .key_cnt_out (key_cnt_out),
    .err_out     (err_out)
  );

  // ---------------- scoreboard state ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [DIM*W:0] exp_q[$];   // MSB = entry is a finished row
  sat_vec_t tbl[11];

  // random-phase variables
  vec_t           p_v, p_o, e_vec;
  bit             pending, p_first, p_last, has, is_row, drain_m, fire_m;
  int             row_pos, row_len, sa, sb;
  logic [DIM*W:0] head;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t splat(input logic [W-1:0] x);
    vec_t r;
    for (int i = 0; i < DIM; i++) r[i] = x;
    return r;
  endfunction

  function automatic logic [W-1:0] clamp(input int s);
    int t;
    if (s > 32767) t = 32767;
    else if (s < -32768) t = -32768;
    else t = s;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_lane();
    logic [W-1:0] r;
    case ($urandom_range(0, 3))
      0: r = 16'h7ff0 + 16'($urandom_range(0, 15));
      1: r = 16'h8000 + 16'($urandom_range(0, 15));
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_vld_in = 0; v_first_in = 0; v_last_in = 0; o_vld_in = 0;
    v_in = '0; o_in = '0;
  endtask

  task automatic drive(input bit first, input bit last, input vec_t vv,
                       input vec_t ov, input bit ovld);
    v_vld_in = 1; v_first_in = first; v_last_in = last;
    v_in = vv; o_in = ov; o_vld_in = ovld;
  endtask

  task automatic apply_reset();
    rst = 1; idle(); fb_rdy_in = 1; row_rdy_in = 1;
    cyc(); cyc();
    rst = 0;
  endtask

  // ---------------- test ----------------
  initial begin
    tbl[0]  = '{16'h0002, 16'h0003, 16'h0005};
    tbl[1]  = '{16'h7fff, 16'h0001, 16'h7fff};
    tbl[2]  = '{16'h8000, 16'hffff, 16'h8000};
    tbl[3]  = '{16'h7fff, 16'h7fff, 16'h7fff};
    tbl[4]  = '{16'h8000, 16'h8000, 16'h8000};
    tbl[5]  = '{16'hfffb, 16'h0003, 16'hfffe};
    tbl[6]  = '{16'h4000, 16'h4000, 16'h7fff};
    tbl[7]  = '{16'hc000, 16'hbfff, 16'h8000};
    tbl[8]  = '{16'h0064, 16'hff9c, 16'h0000};
    tbl[9]  = '{16'h7ffe, 16'h0001, 16'h7fff};
    tbl[10] = '{16'h8001, 16'hffff, 16'h8000};

    // reset state, with a would-be fire held at the inputs
    rst = 1; fb_rdy_in = 1; row_rdy_in = 1;
    drive(1, 1, splat(16'd3), '0, 0);
    cyc();
    chk("rst_v_rdy", v_rdy_out, 0);
    chk("rst_o_rdy", o_rdy_out, 0);
    chk("rst_fb_vld", fb_vld_out, 0);
    chk("rst_row_vld", row_vld_out, 0);
    chk("rst_key_cnt", key_cnt_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_data", row_out, '0);
    rst = 0; idle();
    cyc();

    // single-key row
    drive(1, 1, splat(16'd5), '0, 0);
    #1;
    chk("one_v_rdy", v_rdy_out, 1);
    chk("one_o_rdy", o_rdy_out, 0);
    cyc(); idle();
    chk("one_row_vld", row_vld_out, 1);
    chk("one_fb_vld", fb_vld_out, 0);
    chk("one_row_out", row_out, splat(16'd5));
    chk("one_cnt", key_cnt_out, 1);
    cyc();
    chk("one_drained", row_vld_out, 0);
    chk("one_cnt_clr", key_cnt_out, 0);

    // three-key row with same-cycle drain and refill
    drive(1, 0, splat(16'd3), '0, 0);
    #1;
    chk("k1_o_rdy", o_rdy_out, 0);
    cyc();
    chk("k1_fb_vld", fb_vld_out, 1);
    chk("k1_fb_out", fb_out, splat(16'd3));
    chk("k1_cnt", key_cnt_out, 1);
    drive(0, 0, splat(16'd4), splat(16'd2), 1);
    #1;
    chk("k2_v_rdy", v_rdy_out, 1);
    chk("k2_o_rdy", o_rdy_out, 1);
    cyc();
    chk("k2_fb_out", fb_out, splat(16'd6));
    chk("k2_cnt", key_cnt_out, 2);
    drive(0, 1, splat(16'd1), splat(16'd7), 1);
    #1;
    chk("k3_o_rdy", o_rdy_out, 1);
    cyc(); idle();
    chk("k3_row_vld", row_vld_out, 1);
    chk("k3_fb_vld", fb_vld_out, 0);
    chk("k3_row_out", row_out, splat(16'd8));
    chk("k3_cnt", key_cnt_out, 3);
    cyc();
    chk("k3_cnt_clr", key_cnt_out, 0);

    // saturation table: zero first key, then o + v as the last key
    for (int k = 0; k < 11; k++) begin
      drive(1, 0, '0, '0, 0);
      cyc();
      drive(0, 1, splat(tbl[k].v), splat(tbl[k].o), 1);
      cyc(); idle();
      chk($sformatf("sat_%0d", k), row_out, splat(tbl[k].exp));
      cyc();
    end

    // backpressure on a finished row with a pending fire
    row_rdy_in = 0;
    drive(1, 1, splat(16'd9), '0, 0);
    cyc();
    drive(1, 1, splat(16'd11), '0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_v_rdy", v_rdy_out, 0);
      chk("bp_row_vld", row_vld_out, 1);
      chk("bp_row_out", row_out, splat(16'd9));
      cyc();
    end
    row_rdy_in = 1;
    #1;
    chk("bp_refill_rdy", v_rdy_out, 1);
    cyc(); idle();
    chk("bp_refill_vld", row_vld_out, 1);
    chk("bp_refill_out", row_out, splat(16'd11));
    cyc();
    chk("bp_err_clean", err_out, 0);

    // protocol error: first key while a row is open
    drive(1, 0, splat(16'd1), '0, 0);
    cyc();
    drive(0, 0, splat(16'd1), splat(16'd1), 1);
    cyc();
    chk("pe_cnt2", key_cnt_out, 2);
    chk("pe_err_pre", err_out, 0);
    drive(1, 1, splat(16'd6), '0, 0);
    cyc(); idle();
    chk("pe_err_set", err_out, 1);
    chk("pe_data", row_out, splat(16'd6));
    cyc();
    drive(1, 1, splat(16'd7), '0, 0);
    cyc(); idle();
    chk("pe_clean_row", row_out, splat(16'd7));
    cyc();
    chk("pe_err_sticky", err_out, 1);

    // reset mid-row after two keys
    apply_reset();
    drive(1, 0, splat(16'd2), '0, 0);
    cyc();
    drive(0, 0, splat(16'd2), splat(16'd1), 1);
    cyc();
    fb_rdy_in = 0;
    drive(0, 0, splat(16'd2), splat(16'd1), 1);
    #1;
    chk("mr_cnt2", key_cnt_out, 2);
    rst = 1;
    #1;
    chk("mr_rst_v_rdy", v_rdy_out, 0);
    chk("mr_rst_o_rdy", o_rdy_out, 0);
    cyc();
    rst = 0; idle(); fb_rdy_in = 1;
    chk("mr_fb_vld", fb_vld_out, 0);
    chk("mr_row_vld", row_vld_out, 0);
    chk("mr_cnt", key_cnt_out, 0);
    chk("mr_err", err_out, 0);
    chk("mr_data", fb_out, '0);
    drive(1, 0, splat(16'd4), '0, 0);
    cyc();
    drive(0, 1, splat(16'd3), splat(16'd5), 1);
    cyc(); idle();
    chk("mr_row_vld2", row_vld_out, 1);
    chk("mr_row_out", row_out, splat(16'd8));
    cyc();
    chk("mr_err_after", err_out, 0);

    // randomized rows against the reference model
    apply_reset();
    pending = 0; row_pos = 0; row_len = 1; p_first = 0; p_last = 0;
    p_v = '0; p_o = '0;
    for (int c = 0; c < 800; c++) begin
      if (!pending && $urandom_range(0, 3) != 0) begin
        p_first = (row_pos == 0);
        if (p_first) row_len = $urandom_range(1, 5);
        p_last = (row_pos == row_len - 1);
        for (int i = 0; i < DIM; i++) begin
          p_v[i] = rnd_lane();
          p_o[i] = rnd_lane();
        end
        pending = 1;
      end
      v_vld_in   = pending;
      v_first_in = pending && p_first;
      v_last_in  = pending && p_last;
      v_in = p_v; o_in = p_o;
      o_vld_in   = pending && !p_first && ($urandom_range(0, 3) != 0);
      fb_rdy_in  = ($urandom_range(0, 2) != 0);
      row_rdy_in = ($urandom_range(0, 2) != 0);
      #1;
      has     = (exp_q.size() != 0);
      head    = has ? exp_q[0] : '0;
      is_row  = head[DIM*W];
      drain_m = has && (is_row ? row_rdy_in : fb_rdy_in);
      fire_m  = v_vld_in && (v_first_in || o_vld_in) && (!has || drain_m);
      chk("rnd_v_rdy", v_rdy_out, fire_m);
      chk("rnd_o_rdy", o_rdy_out, fire_m && !v_first_in);
      chk("rnd_fb_vld", fb_vld_out, has && !is_row);
      chk("rnd_row_vld", row_vld_out, has && is_row);
      if (has) chk("rnd_data", is_row ? row_out : fb_out, head[DIM*W-1:0]);
      if (drain_m) void'(exp_q.pop_front());
      if (fire_m) begin
        for (int i = 0; i < DIM; i++) begin
          sa = int'($signed(p_v[i]));
          sb = p_first ? 0 : int'($signed(p_o[i]));
          e_vec[i] = clamp(sa + sb);
        end
        exp_q.push_back({p_last, e_vec});
        pending = 0;
        row_pos = p_last ? 0 : row_pos + 1;
      end
      cyc();
    end
    idle();
    chk("rnd_err", err_out, 0);

    // first fire after reset without a first-key marker
    apply_reset();
    drive(0, 0, splat(16'd1), splat(16'd1), 1);
    cyc(); idle();
    chk("post_rst_err", err_out, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
